// File: rtl/seqgen_pkg.sv
// Shared types for the burst sequence generator: mode encoding, command record and
// small mode helpers used by the engine.
package seqgen_pkg;

  localparam int unsigned SeqModeWidth = 2;
  localparam int unsigned SeqDefWWidth = 8;
  localparam int unsigned SeqDefSWidth = 8;
  localparam int unsigned SeqDefCWidth = 4;

  typedef enum logic [SeqModeWidth-1:0] {
    SEQ_ONESHOT = 2'd0,
    SEQ_REPEAT  = 2'd1,
    SEQ_CONST   = 2'd2
  } seq_mode_e;

  // Command record at the default widths; parametrised instances carry their own copy.
  typedef struct packed {
    logic [SeqDefWWidth-1:0] start;
    logic [SeqDefSWidth-1:0] stride;
    logic [SeqDefCWidth-1:0] count;
    seq_mode_e               mode;
  } seq_cmd_t;

  // The reserved encoding folds onto ONESHOT so stored modes are always legal enumerators.
  function automatic seq_mode_e seq_mode_decode(logic [SeqModeWidth-1:0] raw);
    seq_mode_e m;
    case (raw)
      2'd1:    m = SEQ_REPEAT;
      2'd2:    m = SEQ_CONST;
      default: m = SEQ_ONESHOT;
    endcase
    return m;
  endfunction

  function automatic logic seq_is_repeat(seq_mode_e m);
    return m == SEQ_REPEAT;
  endfunction

  function automatic logic seq_steps(seq_mode_e m);
    return m != SEQ_CONST;
  endfunction

endpackage

// File: rtl/seqgen_cmdq.sv
// Two-slot command store (ACTIVE + PENDING) for the burst generator. Decides whether an
// accepted command starts a pass immediately or waits, and drives the command-side ready.
module seqgen_cmdq
  import seqgen_pkg::*;
#(
  parameter type cmd_t = seq_cmd_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic abort_i,
  input  logic cmd_valid_i,
  input  cmd_t cmd_i,
  input  logic running_i,
  input  logic pass_end_i,
  output logic cmd_ready_o,
  output logic take_o,
  output logic promote_o,
  output logic pend_full_o,
  output cmd_t act_o,
  output cmd_t pend_o
);

  cmd_t act_q, act_d;
  cmd_t pend_q, pend_d;
  logic pend_full_q, pend_full_d;
  logic accept;

  assign cmd_ready_o = !pend_full_q && !abort_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  // A command goes straight to ACTIVE whenever a pass boundary is free to take it.
  assign take_o      = accept && (!running_i || pass_end_i);
  assign promote_o   = pass_end_i && pend_full_q;
  assign pend_full_o = pend_full_q;
  assign act_o       = act_q;
  assign pend_o      = pend_q;

  always_comb begin
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (abort_i) begin
      act_d       = '0;
      pend_d      = '0;
      pend_full_d = 1'b0;
    end else begin
      if (promote_o) begin
        act_d       = pend_q;
        pend_full_d = 1'b0;
      end else if (take_o) begin
        act_d = cmd_i;
      end
      if (accept && !take_o) begin
        pend_d      = cmd_i;
        pend_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

endmodule

// File: rtl/seqgen_burst.sv
// Burst sequence generator: streams Start, Start+Stride, ... over valid/ready, with a
// one-deep command queue so consecutive bursts run back to back.
module seqgen_burst
  import seqgen_pkg::*;
#(
  parameter int unsigned WWIDTH = 8,
  parameter int unsigned SWIDTH = 8,
  parameter int unsigned CWIDTH = 4
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [WWIDTH-1:0] CmdStart,
  input  logic [SWIDTH-1:0] CmdStride,
  input  logic [CWIDTH-1:0] CmdCount,
  input  logic [1:0]        CmdMode,
  input  logic              Abort,
  output logic [WWIDTH-1:0] DataOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              OutFirst,
  output logic              OutLast,
  output logic              Busy
);

  typedef struct packed {
    logic [WWIDTH-1:0] start;
    logic [SWIDTH-1:0] stride;
    logic [CWIDTH-1:0] count;
    seq_mode_e         mode;
  } cmd_t;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [WWIDTH-1:0] data_q, data_d;
  logic [CWIDTH-1:0] rem_q, rem_d;
  logic              first_q, first_d;

  cmd_t              cmd_in, act_cmd, pend_cmd, load_cmd;
  logic              running, xfer, last, pass_end;
  logic              take, promote, pend_full, load;
  logic [WWIDTH-1:0] stride_ext;

  assign cmd_in = '{
    start:  CmdStart,
    stride: CmdStride,
    count:  CmdCount,
    mode:   seq_mode_decode(CmdMode)
  };

  assign running  = state_q == StRun;
  assign xfer     = running && OutReady;
  // rem_q == 0 encodes a full 2^CWIDTH burst, so only 1 marks the final element.
  assign last     = rem_q == CWIDTH'(1);
  assign pass_end = xfer && last && !Abort;

  seqgen_cmdq #(
    .cmd_t (cmd_t)
  ) u_cmdq (
    .clk_i       (Clk),
    .rst_ni      (RstN),
    .abort_i     (Abort),
    .cmd_valid_i (CmdValid),
    .cmd_i       (cmd_in),
    .running_i   (running),
    .pass_end_i  (pass_end),
    .cmd_ready_o (CmdReady),
    .take_o      (take),
    .promote_o   (promote),
    .pend_full_o (pend_full),
    .act_o       (act_cmd),
    .pend_o      (pend_cmd)
  );

  assign stride_ext = WWIDTH'($signed(act_cmd.stride));

  // Next pass source: queued command first, then a fresh one, then a REPEAT restart.
  always_comb begin
    load     = 1'b0;
    load_cmd = act_cmd;
    if (promote) begin
      load     = 1'b1;
      load_cmd = pend_cmd;
    end else if (take) begin
      load     = 1'b1;
      load_cmd = cmd_in;
    end else if (pass_end && seq_is_repeat(act_cmd.mode)) begin
      load     = 1'b1;
      load_cmd = act_cmd;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    first_d = first_q;
    if (Abort) begin
      state_d = StIdle;
    end else if (load) begin
      state_d = StRun;
      data_d  = load_cmd.start;
      rem_d   = load_cmd.count;
      first_d = 1'b1;
    end else if (pass_end) begin
      state_d = StIdle;
    end else if (xfer) begin
      if (seq_steps(act_cmd.mode)) begin
        data_d = data_q + stride_ext;
      end
      rem_d   = rem_q - CWIDTH'(1);
      first_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      first_q <= first_d;
    end
  end

  assign DataOut  = data_q;
  assign OutValid = running;
  assign OutFirst = running && first_q;
  assign OutLast  = running && last;
  assign Busy     = running || pend_full;

endmodule
